// File: rtl/mux_2to1_pkg.sv
// -----------------------------------------------------------------------------
// mux_2to1_pkg
// Shared constants and helpers for the mux_2to1 cell.
//   CNT_W    : width of the optional select-b event counter
//   CNT_MAX  : saturation value of that counter (all ones)
//   sat_inc  : increment that sticks at CNT_MAX instead of wrapping
// -----------------------------------------------------------------------------
package mux_2to1_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating increment: once the counter reaches all ones it stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage : mux_2to1_pkg

// File: rtl/mux_2to1_core.sv
// -----------------------------------------------------------------------------
// mux_2to1_core
// Purely combinational WIDTH-bit 2:1 select.
// Ports:
//   a   [WIDTH-1:0] in  : selected when sel = 0
//   b   [WIDTH-1:0] in  : selected when sel = 1
//   sel             in  : select
//   y   [WIDTH-1:0] out : sel ? b : a
// -----------------------------------------------------------------------------
module mux_2to1_core
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // A plain per-bit ternary: with an unknown sel, bits where a and b agree
  // resolve to that value and the rest go X, which is exactly the intended
  // simulation behaviour, so no extra X handling is added.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
      assign y[gi] = sel ? b[gi] : a[gi];
    end
  endgenerate

endmodule : mux_2to1_core

// File: rtl/mux_2to1.sv
// -----------------------------------------------------------------------------
// mux_2to1
// Parameterised 2:1 multiplexer with a combinational output and a registered,
// enable-gated copy carrying a one-cycle valid flag.
// Optional feature (macro MUX_2TO1_SEL_CNT_EN): a saturating CNT_W-bit counter
// of edges on which b was captured (en=1, sel=1), exposed as sel_b_cnt.
// Ports:
//   clk        in  : rising-edge clock
//   rst_n      in  : synchronous reset, active low
//   a, b       in  : data inputs (WIDTH bits)
//   sel        in  : 0 -> a, 1 -> b
//   en         in  : capture enable for the registered path
//   y          out : combinational mux result
//   y_q        out : registered mux result
//   vld_q      out : y_q was updated on the last rising edge
//   sel_b_cnt  out : (MUX_2TO1_SEL_CNT_EN only) saturating count of b captures
// -----------------------------------------------------------------------------
module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             vld_q
`ifdef MUX_2TO1_SEL_CNT_EN
  ,
  output logic [CNT_W-1:0] sel_b_cnt
`endif
);

  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] y_next;
  logic             vld_reg;
  logic             vld_next;

  // Single select instance feeds both the glue output and the pipeline stage.
  mux_2to1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (a),
    .b   (b),
    .sel (sel),
    .y   (mux_y)
  );

  assign y = mux_y;

  // Hold data when not enabled; valid only pulses on a capture edge.
  always_comb begin
    y_next   = y_reg;
    vld_next = 1'b0;
    if (en) begin
      y_next   = mux_y;
      vld_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg   <= '0;
      vld_reg <= 1'b0;
    end else begin
      y_reg   <= y_next;
      vld_reg <= vld_next;
    end
  end

  assign y_q   = y_reg;
  assign vld_q = vld_reg;

`ifdef MUX_2TO1_SEL_CNT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (en && sel) begin
      cnt_next = sat_inc(cnt_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign sel_b_cnt = cnt_reg;
`endif

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// -----------------------------------------------------------------------------
// tb_mux_2to1
// Directed bench for mux_2to1 with a WIDTH=1 and a WIDTH=8 instance.
// Also exercises the select-b counter when MUX_2TO1_SEL_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mux_2to1;
  import mux_2to1_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic a1, b1, sel1, en1;
  logic y1, y1_q, vld1_q;

  logic [7:0] a8, b8;
  logic       sel8, en8;
  logic [7:0] y8, y8_q;
  logic       vld8_q;

`ifdef MUX_2TO1_SEL_CNT_EN
  logic [CNT_W-1:0] cnt1, cnt8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_2to1 #(.WIDTH(1)) u_w1 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a1),
    .b     (b1),
    .sel   (sel1),
    .en    (en1),
    .y     (y1),
    .y_q   (y1_q),
    .vld_q (vld1_q)
`ifdef MUX_2TO1_SEL_CNT_EN
    ,
    .sel_b_cnt (cnt1)
`endif
  );

  mux_2to1 #(.WIDTH(8)) u_w8 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a8),
    .b     (b8),
    .sel   (sel8),
    .en    (en8),
    .y     (y8),
    .y_q   (y8_q),
    .vld_q (vld8_q)
`ifdef MUX_2TO1_SEL_CNT_EN
    ,
    .sel_b_cnt (cnt8)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs are then changed well away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] v;
    logic       exp_y;

    // Reset held for two edges, WIDTH=8 enabled with sel=1.
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0; en1 = 1'b0;
    a8 = 8'h5A; b8 = 8'hA5; sel8 = 1'b1; en8 = 1'b1;
    #1;
    check("y_in_rst", y8, 8'hA5);
    step();
    check("rst1_yq", y8_q, 8'h00);
    check("rst1_vld", vld8_q, 1'b0);
    check("rst1_y", y8, 8'hA5);
    step();
    check("rst2_yq", y8_q, 8'h00);
    check("rst2_vld", vld8_q, 1'b0);
    check("rst2_y1q", y1_q, 1'b0);
    check("rst2_v1", vld1_q, 1'b0);

    // Release: first capture one edge later.
    rst_n = 1'b1;
    step();
    check("rel_yq", y8_q, 8'hA5);
    check("rel_vld", vld8_q, 1'b1);

    // WIDTH=1 combinational truth table, en=0.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; sel1 = v[0];
      #10;
      exp_y = v[0] ? v[1] : v[2];
      check($sformatf("w1_y_%0d", i), y1, exp_y);
    end
    check("w1_vld_en0", vld1_q, 1'b0);
    check("w1_yq_en0", y1_q, 1'b0);

    // WIDTH=1 registered capture of a.
    a1 = 1'b1; b1 = 1'b0; sel1 = 1'b0; en1 = 1'b1;
    step();
    check("w1_cap_yq", y1_q, 1'b1);
    check("w1_cap_vld", vld1_q, 1'b1);
    en1 = 1'b0;
    step();
    check("w1_hold_yq", y1_q, 1'b1);
    check("w1_hold_vld", vld1_q, 1'b0);

    // Capture 3C, then hold with en=0 while inputs move.
    a8 = 8'h3C; b8 = 8'hC3; sel8 = 1'b0; en8 = 1'b1;
    step();
    check("cap_yq", y8_q, 8'h3C);
    check("cap_vld", vld8_q, 1'b1);
    en8 = 1'b0; a8 = 8'h11; b8 = 8'h22; sel8 = 1'b1;
    #1;
    check("hold_y_b", y8, 8'h22);
    step();
    check("hold_yq1", y8_q, 8'h3C);
    check("hold_vld1", vld8_q, 1'b0);
    sel8 = 1'b0;
    #1;
    check("hold_y_a", y8, 8'h11);
    step();
    check("hold_yq2", y8_q, 8'h3C);
    check("hold_vld2", vld8_q, 1'b0);

    // Reset pulled low for one edge mid-stream with en held high.
    en8 = 1'b1; a8 = 8'h77; sel8 = 1'b0;
    step();
    check("ms_pre_yq", y8_q, 8'h77);
    rst_n = 1'b0; a8 = 8'h88;
    step();
    check("ms_rst_yq", y8_q, 8'h00);
    check("ms_rst_vld", vld8_q, 1'b0);
    rst_n = 1'b1; b8 = 8'h99; sel8 = 1'b1;
    step();
    check("ms_post_yq", y8_q, 8'h99);
    check("ms_post_vld", vld8_q, 1'b1);

`ifdef MUX_2TO1_SEL_CNT_EN
    // Counter: clear, then 5 b-captures and 3 a-captures.
    rst_n = 1'b0; en1 = 1'b0;
    step();
    check("cnt_rst", cnt8, 16'h0000);
    rst_n = 1'b1; en8 = 1'b1; sel8 = 1'b1;
    for (int i = 0; i < 5; i++) step();
    sel8 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("cnt_5", cnt8, 16'd5);
    en8 = 1'b0; sel8 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("cnt_en0", cnt8, 16'd5);
    check("cnt_w1", cnt1, 16'd0);
    // Count up to FFFE, then three more edges must stick at FFFF.
    en8 = 1'b1;
    for (int i = 0; i < 65529; i++) step();
    check("cnt_fffe", cnt8, 16'hFFFE);
    for (int i = 0; i < 3; i++) step();
    check("cnt_sat", cnt8, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_2to1
